// File: rtl/io_gpio_ctrl.sv
// Memory-mapped GPIO block for the IO region (address[12]=1): debounced switches, LED register,
// sticky rising-edge status with maskable irq. Define GPIO_FALL_EDGE_EN to add the FALL register.
module io_gpio_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_W            = 8,
    parameter int LED_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      address,
    input  logic [63:0]      datawrite,
    input  logic             memwr,
    input  logic             memrd,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [63:0]      dataread_io,
    output logic             io_rd_valid,
    output logic [LED_W-1:0] leds,
    output logic             irq
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       io_hit;
    logic [2:0] offset;
    logic       wr_en;
    logic       unused_bits;

    assign io_hit      = address[12];
    assign offset      = address[5:3];
    assign wr_en       = memwr & io_hit;
    assign io_rd_valid = memrd & io_hit;
    assign unused_bits = ^{address[63:13], address[11:6], address[2:0], datawrite};

    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [SW_W-1:0]  sw_stable_q, sw_stable_d, sw_prev_q;
    logic [CNT_W-1:0] cnt_q [SW_W];
    logic [CNT_W-1:0] cnt_d [SW_W];
    logic [LED_W-1:0] leds_q, leds_d;
    logic [SW_W-1:0]  edge_q, edge_d, edge_clr, rise;
    logic [SW_W-1:0]  mask_q, mask_d;
    logic             irq_q, irq_d;
`ifdef GPIO_FALL_EDGE_EN
    logic [SW_W-1:0]  fall_q, fall_d, fall_clr, fell;
`endif

    // Per-bit debounce: a bounce back to the stable level restarts the count.
    always_comb begin
        for (int i = 0; i < SW_W; i++) begin
            cnt_d[i]       = cnt_q[i];
            sw_stable_d[i] = sw_stable_q[i];
            if (sw_s2_q[i] == sw_stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_stable_d[i] = sw_s2_q[i];
                cnt_d[i]       = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rise     = sw_stable_q & ~sw_prev_q;
        leds_d   = leds_q;
        mask_d   = mask_q;
        edge_clr = '0;
`ifdef GPIO_FALL_EDGE_EN
        fell     = sw_prev_q & ~sw_stable_q;
        fall_clr = '0;
`endif
        if (wr_en) begin
            case (offset)
                3'd1: leds_d   = datawrite[LED_W-1:0];
                3'd2: edge_clr = datawrite[SW_W-1:0];
                3'd3: mask_d   = datawrite[SW_W-1:0];
`ifdef GPIO_FALL_EDGE_EN
                3'd4: fall_clr = datawrite[SW_W-1:0];
`endif
                default: ;
            endcase
        end
        // New edges are OR-ed in after the clear so a same-cycle set survives.
        edge_d = (edge_q & ~edge_clr) | rise;
`ifdef GPIO_FALL_EDGE_EN
        fall_d = (fall_q & ~fall_clr) | fell;
        irq_d  = |((edge_q | fall_q) & mask_q);
`else
        irq_d  = |(edge_q & mask_q);
`endif
    end

    always_comb begin
        dataread_io = '0;
        if (io_hit) begin
            case (offset)
                3'd0: dataread_io = 64'(sw_stable_q);
                3'd1: dataread_io = 64'(leds_q);
                3'd2: dataread_io = 64'(edge_q);
                3'd3: dataread_io = 64'(mask_q);
`ifdef GPIO_FALL_EDGE_EN
                3'd4: dataread_io = 64'(fall_q);
`endif
                default: dataread_io = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_stable_q <= '0;
            sw_prev_q   <= '0;
            for (int i = 0; i < SW_W; i++) cnt_q[i] <= '0;
            leds_q      <= '0;
            edge_q      <= '0;
            mask_q      <= '0;
            irq_q       <= 1'b0;
`ifdef GPIO_FALL_EDGE_EN
            fall_q      <= '0;
`endif
        end else begin
            sw_s1_q     <= sw_raw;
            sw_s2_q     <= sw_s1_q;
            sw_stable_q <= sw_stable_d;
            sw_prev_q   <= sw_stable_q;
            for (int i = 0; i < SW_W; i++) cnt_q[i] <= cnt_d[i];
            leds_q      <= leds_d;
            edge_q      <= edge_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
`ifdef GPIO_FALL_EDGE_EN
            fall_q      <= fall_d;
`endif
        end
    end

    assign leds = leds_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_io_gpio_ctrl.sv
// Bench for io_gpio_ctrl: directed register/debounce/irq scenarios, then randomized traffic
// compared every cycle against a window-based behavioural model.
module tb_io_gpio_ctrl;
    localparam int DB    = 16;
    localparam int SW_W  = 8;
    localparam int LED_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] address, datawrite;
    logic        memwr, memrd;
    logic [7:0]  sw_raw;
    logic [63:0] dataread_io;
    logic        io_rd_valid;
    logic [7:0]  leds;
    logic        irq;

    always #10 clk = ~clk;

    io_gpio_ctrl #(.DEBOUNCE_CYCLES(DB), .SW_W(SW_W), .LED_W(LED_W)) dut (
        .clk(clk), .reset(reset), .address(address), .datawrite(datawrite),
        .memwr(memwr), .memrd(memrd), .sw_raw(sw_raw), .dataread_io(dataread_io),
        .io_rd_valid(io_rd_valid), .leds(leds), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: stable value flips once the last DB synchronised samples all disagree with it.
    logic [7:0] m_stable = '0, m_prev = '0, m_edge = '0, m_fall = '0, m_mask = '0, m_leds = '0;
    logic       m_irq = 1'b0;
    logic [7:0] dly[$];
    logic [7:0] win[$];

    function automatic logic [63:0] m_read(input logic [63:0] a);
        if (!a[12]) return '0;
        case (a[5:3])
            3'd0: return 64'(m_stable);
            3'd1: return 64'(m_leds);
            3'd2: return 64'(m_edge);
            3'd3: return 64'(m_mask);
`ifdef GPIO_FALL_EDGE_EN
            3'd4: return 64'(m_fall);
`endif
            default: return '0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [63:0] a, input logic [63:0] wd,
                              input logic wr, input logic [7:0] raw);
        logic [7:0] s2, nxt, rise, clr_e;
        logic       wen, all_diff, nirq;
        if (rst) begin
            m_stable = '0; m_prev = '0; m_edge = '0; m_fall = '0; m_mask = '0; m_leds = '0;
            m_irq = 1'b0;
            dly.delete(); dly.push_back(8'h00); dly.push_back(8'h00);
            win.delete();
            return;
        end
        s2 = dly.pop_front();
        dly.push_back(raw);
        win.push_back(s2);
        if (win.size() > DB) void'(win.pop_front());
        nxt = m_stable;
        if (win.size() == DB) begin
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) nxt[i] = ~m_stable[i];
            end
        end
        rise = m_stable & ~m_prev;
`ifdef GPIO_FALL_EDGE_EN
        nirq = |((m_edge | m_fall) & m_mask);
`else
        nirq = |(m_edge & m_mask);
`endif
        wen   = wr & a[12];
        clr_e = (wen && a[5:3] == 3'd2) ? wd[7:0] : 8'h00;
        m_edge = (m_edge & ~clr_e) | rise;
`ifdef GPIO_FALL_EDGE_EN
        m_fall = (m_fall & ~((wen && a[5:3] == 3'd4) ? wd[7:0] : 8'h00)) | (m_prev & ~m_stable);
`endif
        if (wen && a[5:3] == 3'd3) m_mask = wd[7:0];
        if (wen && a[5:3] == 3'd1) m_leds = wd[7:0];
        m_prev   = m_stable;
        m_stable = nxt;
        m_irq    = nirq;
    endtask

    task automatic tick();
        logic r, w;
        logic [63:0] a, d;
        logic [7:0] s;
        r = reset; w = memwr; a = address; d = datawrite; s = sw_raw;
        @(posedge clk);
        model_edge(r, a, d, w, s);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        address = a; datawrite = d; memwr = 1'b1;
        tick();
        memwr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [63:0] a, input logic [63:0] exp);
        address = a; memrd = 1'b1;
        #1;
        check_eq(tag, dataread_io, exp);
        check_eq({tag, "_vld"}, 64'(io_rd_valid), 64'(a[12]));
        memrd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int lat, e_at, i_at, hold, op;

    initial begin
        reset = 1'b1; address = '0; datawrite = '0; memwr = 1'b0; memrd = 1'b0; sw_raw = '0;
        dly.push_back(8'h00); dly.push_back(8'h00);
        tick(); tick();
        reset = 1'b0;

        rd_chk("rst_sw",   64'h1000, 64'h0);
        rd_chk("rst_led",  64'h1008, 64'h0);
        rd_chk("rst_edge", 64'h1010, 64'h0);
        rd_chk("rst_mask", 64'h1018, 64'h0);
        check_eq("rst_leds", 64'(leds), 64'h0);
        check_eq("rst_irq",  64'(irq),  64'h0);

        wr(64'h1008, 64'hA5);
        check_eq("led_wr", 64'(leds), 64'hA5);
        rd_chk("led_rd", 64'h1008, 64'hA5);
        wr(64'h1000, 64'hFF);
        rd_chk("sw_ro", 64'h1000, 64'h0);
        wr(64'h0008, 64'h3C);
        check_eq("led_nohit", 64'(leds), 64'hA5);
        rd_chk("nohit_rd", 64'h0008, 64'h0);

        address = 64'h1000; sw_raw = 8'h01; lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (lat == 0 && dataread_io[0]) lat = n;
        end
        check_eq("deb_lat", 64'(lat), 64'd18);
        rd_chk("edge_set", 64'h1010, 64'h1);

        sw_raw = 8'h00; do_reset();
        sw_raw = 8'h01; repeat (10) tick();
        sw_raw = 8'h00; repeat (30) tick();
        rd_chk("glitch_sw",   64'h1000, 64'h0);
        rd_chk("glitch_edge", 64'h1010, 64'h0);

        wr(64'h1018, 64'h01);
        rd_chk("mask_rd", 64'h1018, 64'h1);
        address = 64'h1010; sw_raw = 8'h01; e_at = 0; i_at = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (e_at == 0 && dataread_io[0]) e_at = n;
            if (i_at == 0 && irq) i_at = n;
        end
        check_eq("edge_lat", 64'(e_at), 64'd19);
        check_eq("irq_lat", 64'(i_at), 64'(e_at + 1));
        wr(64'h1010, 64'hFE);
        rd_chk("w1c_other", 64'h1010, 64'h1);
        check_eq("irq_hold", 64'(irq), 64'h1);
        wr(64'h1010, 64'h01);
        rd_chk("w1c_clr", 64'h1010, 64'h0);
        tick();
        check_eq("irq_clr", 64'(irq), 64'h0);

        sw_raw = 8'h00; do_reset();
        sw_raw = 8'h01; repeat (18) tick();
        rd_chk("coll_sw", 64'h1000, 64'h1);
        wr(64'h1010, 64'h01);
        rd_chk("coll_edge", 64'h1010, 64'h1);

        do_reset();
        repeat (5) tick();
        do_reset();
        address = 64'h1000; lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (lat == 0 && dataread_io[0]) lat = n;
        end
        check_eq("rst_mid_lat", 64'(lat), 64'd18);

        sw_raw = 8'h00; do_reset();
        wr(64'h1018, 64'h02);
        sw_raw = 8'h02; repeat (20) tick();
        wr(64'h1010, 64'h02);
        repeat (2) tick();
        check_eq("fall_pre_irq", 64'(irq), 64'h0);
        sw_raw = 8'h00; repeat (22) tick();
`ifdef GPIO_FALL_EDGE_EN
        rd_chk("fall_rd", 64'h1020, 64'h2);
        check_eq("fall_irq", 64'(irq), 64'h1);
`else
        wr(64'h1020, 64'hFF);
        rd_chk("fall_rd", 64'h1020, 64'h0);
        check_eq("fall_irq", 64'(irq), 64'h0);
`endif

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                sw_raw = 8'($urandom);
                hold   = int'($urandom_range(1, 40));
            end
            hold--;
            reset = ($urandom_range(0, 699) == 0);
            op    = int'($urandom_range(0, 9));
            address = {$urandom, $urandom};
            address[12]  = ($urandom_range(0, 7) != 0);
            address[5:3] = 3'($urandom_range(0, 7));
            datawrite = {$urandom, $urandom};
            memwr = (op < 3);
            memrd = 1'($urandom_range(0, 1));
            tick();
            check_eq("rnd_leds", 64'(leds), 64'(m_leds));
            check_eq("rnd_irq",  64'(irq),  64'(m_irq));
            check_eq("rnd_rd",   dataread_io, m_read(address));
            check_eq("rnd_vld",  64'(io_rd_valid), 64'(memrd & address[12]));
        end
        memwr = 1'b0; memrd = 1'b0; reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
